// File: rtl/dadda_multiplier_pipe_pkg.sv
// Shared helpers for the pipelined CSA-tree multiplier: tree depth math and the
// sum/carry pair layout used between the reduction and resolve stages.
package dadda_pkg;

  localparam int unsigned DEF_WIDTH  = 8;
  localparam int unsigned DEF_PROD_W = 2 * DEF_WIDTH;

  // Sum/carry pair at the default operand width.
  typedef struct packed {
    logic [DEF_PROD_W-1:0] sum;
    logic [DEF_PROD_W-1:0] carry;
  } csa_pair_t;

  // Dadda stage count: number of heights in 2,3,4,6,9,13,... below the row count.
  function automatic int unsigned csa_levels(input int unsigned rows);
    int unsigned d;
    int unsigned n;
    d = 2;
    n = 0;
    while (d < rows) begin
      n++;
      d = (d * 3) / 2;
    end
    return n;
  endfunction

  // Rows left after a number of row-level 3:2 stages.
  function automatic int unsigned rows_after(input int unsigned rows, input int unsigned levels);
    int unsigned r;
    r = rows;
    for (int unsigned i = 0; i < levels; i++) begin
      r = r - (r / 3);
    end
    return r;
  endfunction

endpackage

// File: rtl/dadda_multiplier_pipe_if.sv
// Operand and product streams of the pipelined multiplier, both valid/ready.
interface dadda_multiplier_pipe_if
  import dadda_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned TAG_W = 4
);

  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic               is_signed;
  logic [TAG_W-1:0]   in_tag;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] p;
  logic [TAG_W-1:0]   out_tag;

  modport master (
    output in_valid, a, b, is_signed, in_tag, out_ready,
    input  in_ready, out_valid, p, out_tag
  );

  modport slave (
    input  in_valid, a, b, is_signed, in_tag, out_ready,
    output in_ready, out_valid, p, out_tag
  );

endinterface

// File: rtl/dadda_multiplier_pipe_csa_row.sv
// W-bit 3:2 compressor; the carry vector is returned unshifted.
module csa_row #(
  parameter int unsigned W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] c,
  output logic [W-1:0] sum,
  output logic [W-1:0] cout
);

  assign sum  = a ^ b ^ c;
  assign cout = (a & b) | (a & c) | (b & c);

endmodule

// File: rtl/dadda_multiplier_pipe.sv
// Two-stage WIDTH x WIDTH multiplier: S1 reduces partial products with a CSA tree,
// S2 resolves sum + carry. Signed/unsigned selected per operation.
module dadda_multiplier_pipe
  import dadda_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned TAG_W = 4
) (
  input logic                    clk,
  input logic                    rst_n,
  dadda_multiplier_pipe_if.slave bus
);

  localparam int unsigned PW     = 2 * WIDTH;
  localparam int unsigned ROWS   = WIDTH + 1;  // partial products plus signed +1 correction
  localparam int unsigned LEVELS = csa_levels(ROWS);

  typedef struct packed {
    logic [PW-1:0] sum;
    logic [PW-1:0] carry;
  } pair_t;

  logic [PW-1:0] ext_a;
  logic [PW-1:0] pp   [ROWS];
  logic [PW-1:0] tree [LEVELS+1][ROWS];

  // Signed mode subtracts the b-MSB row: inverted here, +1 supplied by the last row.
  always_comb begin
    ext_a = bus.is_signed ? {{WIDTH{bus.a[WIDTH-1]}}, bus.a} : {{WIDTH{1'b0}}, bus.a};
    for (int i = 0; i < int'(WIDTH); i++) begin
      pp[i] = bus.b[i] ? (ext_a << i) : '0;
    end
    if (bus.is_signed && bus.b[WIDTH-1]) begin
      pp[WIDTH-1] = ~(ext_a << (WIDTH - 1));
    end
    pp[WIDTH] = PW'(bus.is_signed & bus.b[WIDTH-1]);
  end

  for (genvar r = 0; r < int'(ROWS); r++) begin : g_leaf
    assign tree[0][r] = pp[r];
  end

  for (genvar l = 0; l < int'(LEVELS); l++) begin : g_lvl
    localparam int unsigned R = rows_after(ROWS, l);
    localparam int unsigned G = R / 3;

    for (genvar g = 0; g < int'(G); g++) begin : g_csa
      logic [PW-1:0] s;
      logic [PW-1:0] cy;

      csa_row #(
        .W (PW)
      ) u_csa (
        .a    (tree[l][3*g]),
        .b    (tree[l][3*g+1]),
        .c    (tree[l][3*g+2]),
        .sum  (s),
        .cout (cy)
      );

      assign tree[l+1][2*g]   = s;
      assign tree[l+1][2*g+1] = cy << 1;
    end

    for (genvar k = 3 * G; k < int'(R); k++) begin : g_pass
      assign tree[l+1][k-G] = tree[l][k];
    end

    for (genvar k = R - G; k < int'(ROWS); k++) begin : g_zero
      assign tree[l+1][k] = '0;
    end
  end

  logic en1;
  logic en2;

  logic             s1_valid_q;
  pair_t            s1_q;
  logic [TAG_W-1:0] s1_tag_q;
  logic             out_valid_q;
  logic [PW-1:0]    p_q;
  logic [TAG_W-1:0] out_tag_q;

  assign en2          = !out_valid_q | bus.out_ready;
  assign en1          = !s1_valid_q | en2;
  assign bus.in_ready = en1 & rst_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_q       <= '0;
      s1_tag_q   <= '0;
    end else if (en1) begin
      s1_valid_q <= bus.in_valid;
      if (bus.in_valid) begin
        s1_q.sum   <= tree[LEVELS][0];
        s1_q.carry <= tree[LEVELS][1];
        s1_tag_q   <= bus.in_tag;
      end
    end
  end

  // Carry-out of the final add falls off the top: product is modulo 2**PW.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      p_q         <= '0;
      out_tag_q   <= '0;
    end else if (en2) begin
      out_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        p_q       <= s1_q.sum + s1_q.carry;
        out_tag_q <= s1_tag_q;
      end
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.p         = p_q;
  assign bus.out_tag   = out_tag_q;

endmodule

// File: tb/tb_dadda_multiplier_pipe.sv
// Self-checking bench for dadda_multiplier_pipe: directed corners plus random
// traffic against an arithmetic reference model with a result queue.
module tb_dadda_multiplier_pipe;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned TAG_W = 4;

  typedef struct {
    logic [2*WIDTH-1:0] p;
    logic [TAG_W-1:0]   tag;
    int                 cyc;
  } res_t;

  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;
  int   cyc;
  res_t got_q [$];
  res_t exp_q [$];

  dadda_multiplier_pipe_if #(.WIDTH(WIDTH), .TAG_W(TAG_W)) bus ();

  dadda_multiplier_pipe #(
    .WIDTH (WIDTH),
    .TAG_W (TAG_W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [2*WIDTH-1:0] model(input logic [WIDTH-1:0] x,
                                               input logic [WIDTH-1:0] y, input logic s);
    longint xa;
    longint ya;
    xa = s ? longint'($signed(x)) : longint'(x);
    ya = s ? longint'($signed(y)) : longint'(y);
    return (2*WIDTH)'(xa * ya);
  endfunction

  // Samples both streams mid-cycle, then advances to just after the next rising edge.
  task automatic tick();
    @(negedge clk);
    if (bus.out_valid && bus.out_ready) got_q.push_back('{bus.p, bus.out_tag, cyc});
    if (bus.in_valid && bus.in_ready)
      exp_q.push_back('{model(bus.a, bus.b, bus.is_signed), bus.in_tag, cyc});
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic drive_rand();
    bus.a         = WIDTH'($urandom);
    bus.b         = WIDTH'($urandom);
    bus.is_signed = 1'($urandom);
    bus.in_tag    = TAG_W'($urandom);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    drive_rand();
    @(negedge clk);
    vectors += 4;
    if (bus.out_valid !== 1'b0) begin
      miscompares++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid);
    end
    if (bus.p !== '0) begin
      miscompares++; $display("FAIL reset_p got %h want 0", bus.p);
    end
    if (bus.out_tag !== '0) begin
      miscompares++; $display("FAIL reset_out_tag got %h want 0", bus.out_tag);
    end
    if (bus.in_ready !== 1'b0) begin
      miscompares++; $display("FAIL reset_in_ready got %b want 0", bus.in_ready);
    end
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    vectors++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL post_reset got in_ready=%b out_valid=%b want 1/0", bus.in_ready,
               bus.out_valid);
    end
  endtask

  task automatic test_corners();
    logic [WIDTH-1:0]   ta [6] = '{8'hFF, 8'h80, 8'hFF, 8'h7F, 8'hFF, 8'h80};
    logic [WIDTH-1:0]   tb [6] = '{8'hFF, 8'h80, 8'h01, 8'h80, 8'hFF, 8'h80};
    logic               ts [6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [2*WIDTH-1:0] tp [6] = '{16'hFE01, 16'h4000, 16'hFFFF, 16'hC080, 16'h0001, 16'h4000};
    bus.out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      bus.in_valid  = 1'b1;
      bus.a         = ta[i];
      bus.b         = tb[i];
      bus.is_signed = ts[i];
      bus.in_tag    = TAG_W'(i + 3);
      tick();
      bus.in_valid = 1'b0;
      vectors++;
      if (bus.out_valid !== 1'b0) begin
        miscompares++; $display("FAIL corner%0d_early got out_valid=%b want 0", i, bus.out_valid);
      end
      tick();
      vectors++;
      if (bus.out_valid !== 1'b1 || bus.p !== tp[i] || bus.out_tag !== TAG_W'(i + 3)) begin
        miscompares++;
        $display("FAIL corner%0d got v=%b p=%h tag=%h want v=1 p=%h tag=%h", i, bus.out_valid,
                 bus.p, bus.out_tag, tp[i], TAG_W'(i + 3));
      end
      tick();
    end
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic test_back_to_back();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      bus.in_valid = 1'b1;
      drive_rand();
      vectors++;
      if (bus.in_ready !== 1'b1) begin
        miscompares++; $display("FAIL b2b_in_ready op%0d got %b want 1", i, bus.in_ready);
      end
      tick();
    end
    bus.in_valid = 1'b0;
    for (int n = 0; n < 10 && got_q.size() < 10; n++) tick();
    vectors++;
    if (got_q.size() != 10) begin
      miscompares++; $display("FAIL b2b_count got %0d want 10", got_q.size());
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      vectors++;
      if (got_q[i].p !== exp_q[i].p || got_q[i].tag !== exp_q[i].tag ||
          got_q[i].cyc != got_q[0].cyc + i) begin
        miscompares++;
        $display("FAIL b2b_res%0d got p=%h tag=%h cyc=%0d want p=%h tag=%h cyc=%0d", i,
                 got_q[i].p, got_q[i].tag, got_q[i].cyc, exp_q[i].p, exp_q[i].tag,
                 got_q[0].cyc + i);
      end
    end
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic test_backpressure();
    logic [2*WIDTH-1:0] p0;
    logic [TAG_W-1:0]   t0;
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive_rand();
      tick();
    end
    p0 = bus.p;
    t0 = bus.out_tag;
    vectors++;
    if (exp_q.size() != 2 || bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL bp_stall got accepted=%0d in_ready=%b out_valid=%b want 2/0/1",
               exp_q.size(), bus.in_ready, bus.out_valid);
    end
    tick();
    tick();
    vectors++;
    if (bus.p !== p0 || bus.out_tag !== t0 || exp_q.size() != 2) begin
      miscompares++;
      $display("FAIL bp_hold got p=%h tag=%h accepted=%0d want p=%h tag=%h accepted=2",
               bus.p, bus.out_tag, exp_q.size(), p0, t0);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    for (int n = 0; n < 10 && got_q.size() < 2; n++) tick();
    tick();
    vectors++;
    if (got_q.size() != 2) begin
      miscompares++; $display("FAIL bp_count got %0d want 2", got_q.size());
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      vectors++;
      if (got_q[i].p !== exp_q[i].p || got_q[i].tag !== exp_q[i].tag) begin
        miscompares++;
        $display("FAIL bp_res%0d got p=%h tag=%h want p=%h tag=%h", i, got_q[i].p,
                 got_q[i].tag, exp_q[i].p, exp_q[i].tag);
      end
    end
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic test_reset_mid();
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    drive_rand();
    tick();
    drive_rand();
    tick();
    bus.in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    vectors++;
    if (bus.out_valid !== 1'b0 || bus.p !== '0 || bus.in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL midrst got out_valid=%b p=%h in_ready=%b want 0/0000/0", bus.out_valid,
               bus.p, bus.in_ready);
    end
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    got_q.delete();
    exp_q.delete();
    bus.in_valid = 1'b1;
    drive_rand();
    tick();
    bus.in_valid = 1'b0;
    tick();
    vectors++;
    if (exp_q.size() != 1) begin
      miscompares++; $display("FAIL midrst_accept got %0d want 1", exp_q.size());
    end else if (bus.out_valid !== 1'b1 || bus.p !== exp_q[0].p ||
                 bus.out_tag !== exp_q[0].tag) begin
      miscompares++;
      $display("FAIL midrst_next got v=%b p=%h tag=%h want v=1 p=%h tag=%h", bus.out_valid,
               bus.p, bus.out_tag, exp_q[0].p, exp_q[0].tag);
    end
    tick();
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic test_random();
    for (int n = 0; n < 40000 && exp_q.size() < 10000; n++) begin
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      drive_rand();
      tick();
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    for (int n = 0; n < 10 && got_q.size() < exp_q.size(); n++) tick();
    vectors++;
    if (exp_q.size() != 10000 || got_q.size() != exp_q.size()) begin
      miscompares++;
      $display("FAIL rand_count got in=%0d out=%0d want 10000/10000", exp_q.size(),
               got_q.size());
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      vectors++;
      if (got_q[i].p !== exp_q[i].p || got_q[i].tag !== exp_q[i].tag) begin
        miscompares++;
        $display("FAIL rand_res%0d got p=%h tag=%h want p=%h tag=%h", i, got_q[i].p,
                 got_q[i].tag, exp_q[i].p, exp_q[i].tag);
      end
    end
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    cyc         = 0;
    test_reset();
    test_corners();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
